deserializer: RTL and testbench

Serial-to-parallel receiver for the test-clock serial link: samples a 1-bit MSB-first stream on `t_clk`, finds word alignment by hunting for a fixed sync word, then delivers each subsequent `WIDTH`-bit word on a parallel bus with a one-cycle valid strobe. It is the receiving end of the serializer in the self-test path. Every transmit session sends `SYNC_WORD` once, then data words back-to-back with no gaps.

---
 rtl/deserializer.sv | 99 +++++++++
 tb/tb_deserializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: hunts for SYNC_WORD on an MSB-first bit stream,
// then delivers each following WIDTH-bit word with a one-cycle valid strobe.
module deserializer #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   SYNC_WORD = WIDTH'(8'hA5)
) (
   input  logic             t_clk,
   input  logic             rst_n,
   input  logic             data_in,
   input  logic             resync,
   input  logic             bit_slip,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             locked,
   output logic [7:0]       word_cnt
);

   localparam int            BW   = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   typedef enum logic {
      HUNT,
      LOCKED
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [WIDTH-1:0] data_out_nxt;
   logic             data_valid_nxt;
   logic [7:0]       word_cnt_nxt;

   assign nxt    = {sr[WIDTH-2:0], data_in};
   assign locked = (state == LOCKED);

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      data_out_nxt   = data_out;
      data_valid_nxt = 1'b0;
      word_cnt_nxt   = word_cnt;

      // resync wins over lock detection, slip and word completion alike
      if (resync) begin
         state_nxt   = HUNT;
         bit_cnt_nxt = '0;
      end else begin
         case (state)
            HUNT: begin
               bit_cnt_nxt = '0;
               if (nxt == SYNC_WORD) begin
                  state_nxt    = LOCKED;
                  word_cnt_nxt = 8'd0;
               end
            end
            LOCKED: begin
               if (bit_slip) begin
                  bit_cnt_nxt = bit_cnt;
               end else if (bit_cnt == LAST) begin
                  data_out_nxt   = nxt;
                  data_valid_nxt = 1'b1;
                  word_cnt_nxt   = word_cnt + 8'd1;
                  bit_cnt_nxt    = '0;
               end else begin
                  bit_cnt_nxt = bit_cnt + BW'(1);
               end
            end
            default: begin
               state_nxt   = HUNT;
               bit_cnt_nxt = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         sr         <= '0;
         bit_cnt    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         word_cnt   <= 8'd0;
      end else begin
         state      <= state_nxt;
         sr         <= nxt;
         bit_cnt    <= bit_cnt_nxt;
         data_out   <= data_out_nxt;
         data_valid <= data_valid_nxt;
         word_cnt   <= word_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: lock, hunt offset, bit slip, resync,
// asynchronous reset mid-word and word counter wrap.
module tb_deserializer;

   localparam logic [7:0] SYNC = 8'hA5;

   logic       t_clk    = 1'b0;
   logic       rst_n    = 1'b0;
   logic       data_in  = 1'b0;
   logic       resync   = 1'b0;
   logic       bit_slip = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       locked;
   logic [7:0] word_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         c81     = 0;
   int         vcyc[$];
   logic [7:0] vdat[$];

   always #5 t_clk = ~t_clk;

   deserializer #(.WIDTH(8), .SYNC_WORD(8'hA5)) dut (
      .t_clk      (t_clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .resync     (resync),
      .bit_slip   (bit_slip),
      .data_out   (data_out),
      .data_valid (data_valid),
      .locked     (locked),
      .word_cnt   (word_cnt)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // drive one bit at the falling edge, sample outputs 1 ns after the rising edge
   task automatic step(input logic b, input logic slip, input logic rs);
      @(negedge t_clk);
      data_in  = b;
      bit_slip = slip;
      resync   = rs;
      @(posedge t_clk);
      #1;
      cyc++;
      if (data_valid === 1'b1) begin
         vcyc.push_back(cyc);
         vdat.push_back(data_out);
      end
      bit_slip = 1'b0;
      resync   = 1'b0;
   endtask

   task automatic send(input logic [7:0] w, input int slip_at);
      for (int i = 0; i < 8; i++) step(w[7-i], (i == slip_at), 1'b0);
   endtask

   task automatic clear_q();
      vcyc.delete();
      vdat.delete();
   endtask

   function automatic logic [7:0] qd(input int i);
      return (vdat.size() > i) ? vdat[i] : 8'hxx;
   endfunction

   function automatic int qc(input int i);
      return (vcyc.size() > i) ? vcyc[i] : -1000;
   endfunction

   // sends the sync word; locked must stay low until its last bit is sampled
   task automatic sync_and_check(input string tag);
      logic [7:0] w;
      w = SYNC;
      for (int i = 0; i < 7; i++) step(w[7-i], 1'b0, 1'b0);
      check({tag, " locked before last sync bit"}, 32'(locked), 32'd0);
      step(w[0], 1'b0, 1'b0);
      check({tag, " locked after sync"}, 32'(locked), 32'd1);
      check({tag, " no valid while hunting"}, 32'(vcyc.size()), 32'd0);
   endtask

   initial begin
      // reset state
      #12;
      check("reset data_out", 32'(data_out), 32'h0);
      check("reset data_valid", 32'(data_valid), 32'd0);
      check("reset locked", 32'(locked), 32'd0);
      check("reset word_cnt", 32'(word_cnt), 32'd0);
      @(negedge t_clk);
      rst_n = 1'b1;

      // sync then two data words
      clear_q();
      sync_and_check("t1");
      check("t1 data_out at lock", 32'(data_out), 32'h0);
      check("t1 word_cnt at lock", 32'(word_cnt), 32'd0);
      send(8'h3C, -1);
      send(8'hFF, -1);
      check("t1 valid count", 32'(vdat.size()), 32'd2);
      check("t1 word0", 32'(qd(0)), 32'h3C);
      check("t1 word1", 32'(qd(1)), 32'hFF);
      check("t1 valid spacing", 32'(qc(1) - qc(0)), 32'd8);
      check("t1 word_cnt", 32'(word_cnt), 32'd2);

      // hunt offset: five leading ones, then sync, then 0x81
      @(negedge t_clk);
      rst_n = 1'b0;
      @(negedge t_clk);
      rst_n = 1'b1;
      clear_q();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      sync_and_check("t2");
      send(8'h81, -1);
      check("t2 valid count", 32'(vdat.size()), 32'd1);
      check("t2 word", 32'(qd(0)), 32'h81);
      check("t2 word_cnt", 32'(word_cnt), 32'd1);
      c81 = qc(0);

      // bit slip on the 4th bit of 0x55: boundary moves one bit late, so the
      // delivered word is the last seven bits of 0x55 plus the first bit of 0x00
      clear_q();
      send(8'h80, -1);
      send(8'h55, 3);
      send(8'h00, -1);
      check("t3 valid count", 32'(vdat.size()), 32'd2);
      check("t3 word0", 32'(qd(0)), 32'h80);
      check("t3 word1 slipped", 32'(qd(1)), 32'hAA);
      check("t3 spacing before slip", 32'(qc(0) - c81), 32'd8);
      check("t3 spacing across slip", 32'(qc(1) - qc(0)), 32'd9);
      check("t3 word_cnt", 32'(word_cnt), 32'd3);

      // resync mid-word; first bit of 0xE7 completes the pending word 0x01
      clear_q();
      step(1'b1, 1'b0, 1'b0);
      check("t4 pending word valid", 32'(data_valid), 32'd1);
      check("t4 pending word", 32'(data_out), 32'h01);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check("t4 locked after resync", 32'(locked), 32'd0);
      check("t4 valid after resync", 32'(data_valid), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t4 data_out held", 32'(data_out), 32'h01);
      check("t4 word_cnt held", 32'(word_cnt), 32'd4);
      check("t4 valid count", 32'(vdat.size()), 32'd1);
      clear_q();
      sync_and_check("t4 relock");
      send(8'h5A, -1);
      check("t4 relock valid count", 32'(vdat.size()), 32'd1);
      check("t4 relock word", 32'(qd(0)), 32'h5A);
      check("t4 relock word_cnt", 32'(word_cnt), 32'd1);

      // asynchronous reset between edges during the third word
      send(8'h11, -1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("t5 data_out before reset", 32'(data_out), 32'h11);
      check("t5 locked before reset", 32'(locked), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5 reset data_out", 32'(data_out), 32'h0);
      check("t5 reset data_valid", 32'(data_valid), 32'd0);
      check("t5 reset locked", 32'(locked), 32'd0);
      check("t5 reset word_cnt", 32'(word_cnt), 32'd0);
      @(negedge t_clk);
      @(negedge t_clk);
      rst_n = 1'b1;
      clear_q();
      sync_and_check("t5 relock");
      send(8'h42, -1);
      check("t5 relock word", 32'(qd(0)), 32'h42);
      check("t5 relock word_cnt", 32'(word_cnt), 32'd1);

      // word counter wrap: 256 words delivered since lock
      for (int w = 1; w < 255; w++) send(8'(w), -1);
      check("t6 word_cnt at 255", 32'(word_cnt), 32'd255);
      send(8'hFF, -1);
      check("t6 word_cnt wrapped", 32'(word_cnt), 32'd0);
      check("t6 last word", 32'(data_out), 32'hFF);
      check("t6 valid count", 32'(vdat.size()), 32'd256);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
